spike_encoder: RTL and testbench

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/spike_encoder.sv | 123 ++++++++++++
 tb/tb_spike_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: turns per-channel intensities into a TIMESTEPS-long spike train.
// Define SPIKE_ENCODER_DETERMINISTIC_EN for phase-accumulator coding; default is per-channel LFSR coding.

module spike_lane #(
  parameter int          W    = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] intensity,
  output logic         spike
);
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
  logic [W-1:0] acc;
  logic [W:0]   sum;

  // Carry-out of acc+intensity fires exactly floor(n*I/2^W) times over n steps.
  assign sum   = {1'b0, acc} + {1'b0, intensity};
  assign spike = sum[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc <= '0;
    else if (clear)   acc <= '0;
    else if (advance) acc <= sum[W-1:0];
  end
`else
  // A zero seed would lock the LFSR, so fall back to the default seed.
  localparam logic [15:0] START = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lfsr <= START;
    else if (clear)   lfsr <= START;
    else if (advance) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Random-mode comparison uses the low W bits, so W must not exceed 16.
  assign spike = lfsr[W-1:0] < intensity;
`endif
endmodule

module spike_encoder #(
  parameter int          NUM_INPUTS      = 4,
  parameter int          INTENSITY_WIDTH = 8,
  parameter int          TIMESTEPS       = 100,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_valid,
  output logic                                  load_ready,
  input  logic [NUM_INPUTS*INTENSITY_WIDTH-1:0] load_data,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  spike_valid,
  output logic [NUM_INPUTS-1:0]                 spike_out,
  output logic [15:0]                           timestep
);
  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  RUN  = 2'd1;
  localparam logic [1:0]  DONE = 2'd2;
  localparam logic [15:0] LAST = 16'(TIMESTEPS - 1);

  logic [1:0]                                 state;
  logic [15:0]                                count;
  logic [NUM_INPUTS-1:0][INTENSITY_WIDTH-1:0] intensity;
  logic [NUM_INPUTS-1:0]                      raw;
  logic                                       go;

  assign go = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          count <= '0;
        end
        RUN: begin
          if (count == LAST) state <= DONE;
          else               count <= count + 16'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A load coinciding with start lands here on the same edge, so timestep 0 already sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          intensity <= '0;
    else if (load_valid && load_ready) intensity <= load_data;
  end

  generate
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      spike_lane #(
        .W    (INTENSITY_WIDTH),
        .SEED (LFSR_SEED ^ 16'(i))
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .clear     (go),
        .advance   (state == RUN),
        .intensity (intensity[i]),
        .spike     (raw[i])
      );
    end
  endgenerate

  assign load_ready  = (state == IDLE);
  assign busy        = (state == RUN) || (state == DONE);
  assign done        = (state == DONE);
  assign spike_valid = (state == RUN);
  assign spike_out   = spike_valid ? raw : '0;
  assign timestep    = count;
endmodule

// File: tb/tb_spike_encoder.sv
// Randomized bench for spike_encoder with a per-cycle behavioural reference model.
module tb_spike_encoder;
  localparam int          N    = 4;
  localparam int          W    = 8;
  localparam int          T    = 100;
  localparam logic [15:0] SEED = 16'hACE1;

  logic           clk = 0, rst = 1, load_valid = 0, start = 0;
  logic [N*W-1:0] load_data = '0;
  logic           load_ready, busy, done, spike_valid;
  logic [N-1:0]   spike_out;
  logic [15:0]    timestep;

  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;

  spike_encoder #(.NUM_INPUTS(N), .INTENSITY_WIDTH(W), .TIMESTEPS(T), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .start(start), .busy(busy), .done(done),
    .spike_valid(spike_valid), .spike_out(spike_out), .timestep(timestep)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel ch's generator state after n advances from its start seed.
  function automatic logic [15:0] lfsr_after(input int ch, input int n);
    logic [15:0] s;
    s = SEED ^ 16'(ch);
    if (s == 16'h0) s = 16'hACE1;
    for (int k = 0; k < n; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  // Deterministic coding: a spike at step t iff the running count floor(n*I/2^W) ticks up.
  function automatic bit det_spike(input int t, input int inten);
    return (((t + 1) * inten) >> W) != ((t * inten) >> W);
  endfunction

  // Reference model: phase 0 idle, 1 run (step m_t), 2 done.
  int m_phase = 0, m_t = 0;
  int m_int[N] = '{default: 0};

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_t = 0;
      foreach (m_int[i]) m_int[i] = 0;
    end else begin
      case (m_phase)
        0: begin
          if (load_valid) foreach (m_int[i]) m_int[i] = int'(load_data[i*W +: W]);
          if (start) begin m_phase = 1; m_t = 0; end
        end
        1: if (m_t == T - 1) m_phase = 2; else m_t++;
        default: m_phase = 0;
      endcase
    end
  end

  // Monitor state used by the per-train checks.
  int           vcnt, first_valid, first_ts, done_cyc;
  int           cnt[N];
  logic [N-1:0] seq_cur[T], seq_a[T];
  logic [N-1:0] es;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", spike_valid, 0);
      check("rst_spike", spike_out, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", load_ready, 1);
      check("rst_timestep", timestep, 0);
    end else begin
      es = '0;
      if (m_phase == 1)
        for (int i = 0; i < N; i++) begin
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
          es[i] = det_spike(m_t, m_int[i]);
`else
          es[i] = int'(lfsr_after(i, m_t) & 16'((1 << W) - 1)) < m_int[i];
`endif
        end
      check("spike_valid", spike_valid, m_phase == 1);
      check("spike_out", spike_out, es);
      check("done", done, m_phase == 2);
      check("busy", busy, m_phase != 0);
      check("load_ready", load_ready, m_phase == 0);
      if (m_phase == 1) check("timestep", timestep, m_t);
      if (spike_valid) begin
        if (first_valid < 0) begin first_valid = cyc; first_ts = int'(timestep); end
        vcnt++;
        for (int i = 0; i < N; i++) cnt[i] += int'(spike_out[i]);
        if (int'(timestep) < T) seq_cur[timestep] = spike_out;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    vcnt = 0; first_valid = -1; first_ts = -1; done_cyc = -1;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (seq_cur[t]) seq_cur[t] = '0;
  endtask

  task automatic run_train(input logic [N*W-1:0] data, input bit do_load, input bit disturb);
    int n0, k;
    clear_mon();
    @(posedge clk); #1;
    load_valid = do_load; load_data = data; start = 1; n0 = cyc;
    @(posedge clk); #1;
    load_valid = 0; start = 0;
    if (disturb) begin
      repeat ($urandom_range(5, 60)) @(posedge clk);
      #1; load_valid = 1; load_data = $urandom; start = 1;
      @(posedge clk); #1; load_valid = 0; start = 0;
    end
    k = 0;
    while (done_cyc < 0 && k < 400) begin @(posedge clk); k++; end
    check("done_seen", done_cyc >= 0, 1);
    while (cyc < n0 + T + 2 && k < 800) begin @(posedge clk); k++; end
    @(negedge clk);
    check("ready_after_done", load_ready, 1);
    check("valid_count", vcnt, T);
    check("first_valid_offset", first_valid - n0, 1);
    check("first_timestep", first_ts, 0);
    check("done_offset", done_cyc - n0, T + 1);
  endtask

  initial begin
    int mism, k, s;
    clear_mon();

    // Pin the model against hand-computed values.
    check("model_lfsr_step1", lfsr_after(0, 1), 16'h59C3);
    check("model_det_t0", det_spike(0, 128), 0);
    check("model_det_t1", det_spike(1, 128), 1);
    s = 0;
    for (int t = 0; t < T; t++) s += int'(det_spike(t, 64));
    check("model_det_count64", s, 25);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("idle_ready", load_ready, 1);
    check("idle_busy", busy, 0);

    // Intensities {0,64,128,255} on channels 0..3, disturbed by load/start mid-train.
    run_train({8'd255, 8'd128, 8'd64, 8'd0}, 1, 1);
    check("cnt_zero", cnt[0], 0);
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
    check("cnt_64", cnt[1], 25);
    check("cnt_128", cnt[2], 50);
    check("cnt_255", cnt[3], 99);
    mism = 0;
    for (int t = 0; t < T; t++) if (seq_cur[t][2] != (t % 2 == 1)) mism++;
    check("ch2_odd_steps", mism, 0);
`else
    check("cnt_255_range", (cnt[3] >= 90 && cnt[3] <= 100), 1);
`endif
    foreach (seq_a[t]) seq_a[t] = seq_cur[t];

    // Same intensities again without reloading: identical train.
    run_train('0, 0, 0);
    mism = 0;
    for (int t = 0; t < T; t++) if (seq_cur[t] !== seq_a[t]) mism++;
    check("repeat_identical", mism, 0);
    check("repeat_cnt_zero", cnt[0], 0);

    // Random intensities, some with disturbances.
    for (int r = 0; r < 4; r++) begin
      logic [N*W-1:0] d;
      d = $urandom;
      if (r == 1) d[W-1:0] = '0;
      run_train(d, 1, bit'(r[0]));
      if (r == 1) check("rand_zero_channel", cnt[0], 0);
    end

    // Reset mid-train at timestep 40.
    clear_mon();
    @(posedge clk); #1;
    load_valid = 1; load_data = {8'd200, 8'd100, 8'd50, 8'd10}; start = 1;
    @(posedge clk); #1;
    load_valid = 0; start = 0;
    k = 0;
    while (k < 300) begin
      @(negedge clk); k++;
      if (spike_valid && timestep == 16'd40) break;
    end
    check("reached_ts40", (spike_valid && timestep == 16'd40), 1);
    #2 rst = 1;
    #1;
    check("abort_valid", spike_valid, 0);
    check("abort_spike", spike_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ts", timestep, 0);
    check("abort_ready", load_ready, 1);
    @(posedge clk); #1 rst = 0;
    done_cyc = -1;
    repeat (150) @(posedge clk);
    check("no_done_after_abort", done_cyc, -1);

    run_train({8'd200, 8'd100, 8'd50, 8'd10}, 1, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
